// File: rtl/counter_ctrl.sv
// counter_ctrl
//
// Command-driven sequencer for an external WIDTH-bit up counter. It accepts
// START / STOP / PAUSE-RESUME commands over a valid/ready handshake. On START
// it clears the counter and then gates the counter's enable until the
// programmed terminal count is reached. At terminal count it pulses done and
// bumps the period counter. It then either returns to idle (one-shot) or
// clears the counter and runs again (periodic).
//
// Ports
//   clock         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   cmd_valid     command present
//   cmd_ready     command accepted when cmd_valid && cmd_ready at rising edge
//   cmd_op        00 NOP, 01 START, 10 STOP, 11 PAUSE/RESUME
//   cmd_limit     terminal count, sampled on an accepted START
//   cmd_periodic  auto-reload after terminal, sampled on an accepted START
//   cnt_reset     active-high clear to the counter
//   cnt_enable    count enable to the counter
//   cnt_value     counter's current count
//   busy          sequencer is not idle
//   done          one-cycle pulse at terminal count
//   periods       completed periods since the last START (wraps)
module counter_ctrl #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_limit,
    input  logic              cmd_periodic,
    output logic              cnt_reset,
    output logic              cnt_enable,
    input  logic [WIDTH-1:0]  cnt_value,
    output logic              busy,
    output logic              done,
    output logic [PCNT_W-1:0] periods
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_PAUSE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_RUN    = 2'd2,
        S_PAUSED = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [WIDTH-1:0]    limit_reg, limit_next;
    logic                periodic_reg, periodic_next;
    logic                done_reg, done_next;
    logic [PCNT_W-1:0]   periods_reg, periods_next;

    logic cmd_accept;
    logic is_start, is_stop, is_pause;
    logic terminal;

    assign cmd_ready  = (state_reg != S_CLEAR);
    assign cmd_accept = cmd_valid && cmd_ready;
    assign is_start   = cmd_accept && (cmd_op == OP_START);
    assign is_stop    = cmd_accept && (cmd_op == OP_STOP);
    assign is_pause   = cmd_accept && (cmd_op == OP_PAUSE);
    assign terminal   = (cnt_value == limit_reg);

    // Holding the counter clear while reset_n is low means it comes out of
    // system reset at 0 without needing its own reset connection.
    assign cnt_reset  = ~reset_n | (state_reg == S_CLEAR);
    // Combinational gate so the counter stops on the very value that matches.
    assign cnt_enable = (state_reg == S_RUN) && !terminal;
    assign busy       = (state_reg != S_IDLE);
    assign done       = done_reg;
    assign periods    = periods_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            limit_reg    <= '0;
            periodic_reg <= 1'b0;
            done_reg     <= 1'b0;
            periods_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            limit_reg    <= limit_next;
            periodic_reg <= periodic_next;
            done_reg     <= done_next;
            periods_reg  <= periods_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        limit_next    = limit_reg;
        periodic_next = periodic_reg;
        done_next     = 1'b0;
        periods_next  = periods_reg;

        case (state_reg)
            S_IDLE: begin
                // STOP and PAUSE are accepted here but have nothing to act on.
                if (is_start) begin
                    limit_next    = cmd_limit;
                    periodic_next = cmd_periodic;
                    periods_next  = '0;
                    state_next    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                // STOP/START pre-empt a coincident terminal match (no done);
                // a PAUSE coinciding with the match is swallowed.
                if (is_stop) begin
                    state_next = S_IDLE;
                end else if (is_start) begin
                    limit_next    = cmd_limit;
                    periodic_next = cmd_periodic;
                    periods_next  = '0;
                    state_next    = S_CLEAR;
                end else if (terminal) begin
                    done_next    = 1'b1;
                    periods_next = periods_reg + PCNT_W'(1);
                    state_next   = periodic_reg ? S_CLEAR : S_IDLE;
                end else if (is_pause) begin
                    state_next = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (is_stop) begin
                    state_next = S_IDLE;
                end else if (is_start) begin
                    limit_next    = cmd_limit;
                    periodic_next = cmd_periodic;
                    periods_next  = '0;
                    state_next    = S_CLEAR;
                end else if (is_pause) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // OP_NOP needs no handling: it is accepted and changes nothing.
    logic unused_op_nop;
    assign unused_op_nop = (cmd_op == OP_NOP);

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

    localparam int WIDTH  = 4;
    localparam int PCNT_W = 8;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_limit;
    logic              cmd_periodic;
    logic              cnt_reset;
    logic              cnt_enable;
    logic [WIDTH-1:0]  cnt_value;
    logic              busy;
    logic              done;
    logic [PCNT_W-1:0] periods;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    // Behavioural 4-bit up counter: synchronous clear has priority over enable.
    always_ff @(posedge clock) begin
        if (cnt_reset)       cnt_value <= '0;
        else if (cnt_enable) cnt_value <= cnt_value + 4'd1;
    end

    counter_ctrl #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_limit   (cmd_limit),
        .cmd_periodic(cmd_periodic),
        .cnt_reset   (cnt_reset),
        .cnt_enable  (cnt_enable),
        .cnt_value   (cnt_value),
        .busy        (busy),
        .done        (done),
        .periods     (periods)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("[TB] check %-20s observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one command for exactly one edge.
    task automatic send(input logic [1:0] op, input logic [3:0] lim, input logic per);
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_limit    = lim;
        cmd_periodic = per;
        tick();
        cmd_valid    = 1'b0;
        cmd_op       = 2'b00;
    endtask

    initial begin
        reset_n      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = 2'b00;
        cmd_limit    = '0;
        cmd_periodic = 1'b0;

        // ---- Reset state ----
        tick();
        tick();
        check("rst_busy",      32'(busy),       0);
        check("rst_cmd_ready", 32'(cmd_ready),  1);
        check("rst_cnt_reset", 32'(cnt_reset),  1);
        check("rst_cnt_enable",32'(cnt_enable), 0);
        check("rst_done",      32'(done),       0);
        check("rst_periods",   32'(periods),    0);
        check("rst_cnt_value", 32'(cnt_value),  0);
        reset_n = 1'b1;
        tick();
        check("post_rst_cnt_reset", 32'(cnt_reset), 0);

        // PAUSE while idle is ignored
        send(2'b11, 4'd0, 1'b0);
        check("idle_pause_busy", 32'(busy), 0);

        // ---- L=5 one-shot ----
        send(2'b01, 4'd5, 1'b0);                       // E0
        check("os_clear_cnt_reset", 32'(cnt_reset), 1);
        check("os_clear_ready",     32'(cmd_ready), 0);
        check("os_clear_busy",      32'(busy),      1);
        tick();                                         // E1
        check("os_e1_cnt",    32'(cnt_value),  0);
        check("os_e1_enable", 32'(cnt_enable), 1);
        check("os_e1_rst",    32'(cnt_reset),  0);
        for (int n = 1; n <= 5; n++) begin
            tick();                                     // E(1+n)
            check("os_cnt", 32'(cnt_value), 32'(n));
            check("os_done_low", 32'(done), 0);
        end
        check("os_match_enable", 32'(cnt_enable), 0);
        tick();                                         // E7
        check("os_done",    32'(done),      1);
        check("os_busy",    32'(busy),      0);
        check("os_periods", 32'(periods),   1);
        check("os_cnt_hold",32'(cnt_value), 5);
        tick();
        check("os_done_fall", 32'(done),      0);
        check("os_cnt_hold2", 32'(cnt_value), 5);

        // ---- L=3 periodic, 20 cycles ----
        send(2'b01, 4'd3, 1'b1);                       // E0
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("per_done", 32'(done), (k >= 5 && (k % 5) == 0) ? 1 : 0);
            check("per_periods", 32'(periods), 32'(k / 5));
            check("per_cnt_le3", 32'(cnt_value <= 4'd3), 1);
        end
        tick();                                         // CLEAR -> RUN
        send(2'b10, 4'd0, 1'b0);
        check("per_stop_busy",    32'(busy),    0);
        check("per_stop_periods", 32'(periods), 4);

        // ---- L=9 with pause at count 4 for 3 cycles ----
        send(2'b01, 4'd9, 1'b0);                       // E0
        for (int k = 1; k <= 4; k++) tick();            // E4
        check("pz_cnt3", 32'(cnt_value), 3);
        send(2'b11, 4'd0, 1'b0);                       // E5: paused
        check("pz_cnt4",     32'(cnt_value),  4);
        check("pz_enable",   32'(cnt_enable), 0);
        check("pz_busy",     32'(busy),       1);
        tick();
        check("pz_hold_a", 32'(cnt_value), 4);
        tick();
        check("pz_hold_b", 32'(cnt_value), 4);
        send(2'b11, 4'd0, 1'b0);                       // E8: resume
        check("pz_hold_c",   32'(cnt_value),  4);
        check("pz_resume_en",32'(cnt_enable), 1);
        for (int k = 9; k <= 13; k++) begin
            tick();
            check("pz_cnt", 32'(cnt_value), 32'(k - 4));
            check("pz_done_low", 32'(done), 0);
        end
        tick();                                         // E14
        check("pz_done",    32'(done),    1);
        check("pz_periods", 32'(periods), 1);
        check("pz_busy_end",32'(busy),    0);

        // ---- L=7 STOP coinciding with terminal match ----
        send(2'b01, 4'd7, 1'b0);                       // E0
        for (int k = 1; k <= 8; k++) tick();            // E8
        check("st_cnt7",   32'(cnt_value),  7);
        check("st_enable", 32'(cnt_enable), 0);
        send(2'b10, 4'd0, 1'b0);                       // E9
        check("st_done",    32'(done),      0);
        check("st_busy",    32'(busy),      0);
        check("st_periods", 32'(periods),   0);
        check("st_cnt",     32'(cnt_value), 7);
        tick();
        check("st_done2", 32'(done), 0);

        // ---- L=0 periodic ----
        send(2'b01, 4'd0, 1'b1);                       // E0
        check("z_clear_enable", 32'(cnt_enable), 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("z_done", 32'(done), (k >= 2 && (k % 2) == 0) ? 1 : 0);
            check("z_enable", 32'(cnt_enable), 0);
            check("z_periods", 32'(periods), 32'(k / 2));
        end
        tick();
        send(2'b10, 4'd0, 1'b0);
        check("z_stop_busy", 32'(busy), 0);

        // ---- Reset mid-run at count 6 ----
        send(2'b01, 4'd12, 1'b1);                      // E0
        for (int k = 1; k <= 7; k++) tick();            // E7
        check("mr_cnt6",   32'(cnt_value), 6);
        check("mr_busy",   32'(busy),      1);
        reset_n = 1'b0;
        #1;
        check("mr_busy_rst",   32'(busy),       0);
        check("mr_enable_rst", 32'(cnt_enable), 0);
        check("mr_ready_rst",  32'(cmd_ready),  1);
        check("mr_creset_rst", 32'(cnt_reset),  1);
        check("mr_done_rst",   32'(done),       0);
        check("mr_periods_rst",32'(periods),    0);
        tick();
        check("mr_cnt_clear", 32'(cnt_value), 0);
        reset_n = 1'b1;
        tick();
        // NOP while idle: no effect
        send(2'b00, 4'd0, 1'b0);
        check("mr_nop_busy", 32'(busy), 0);
        send(2'b01, 4'd2, 1'b0);                       // E0
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("mr2_cnt", 32'(cnt_value), 32'(k - 1));
        end
        tick();                                         // E4
        check("mr2_done",    32'(done),    1);
        check("mr2_periods", 32'(periods), 1);
        check("mr2_busy",    32'(busy),    0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
